// File: rtl/inst_fetch_queue.sv
// Instruction-fetch stage: owns the PC, issues one cache fetch at a time and queues returned words for decode.
// Optional static branch prediction is enabled by defining STATIC_BRANCH_PREDICT_EN.
module inst_fetch_queue #(
    parameter int          QUEUE_ADDR_W = 3,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear_up,
    input  logic [31:0] rob_new_pc,
    output logic        start_fetch,
    output logic [31:0] pc,
    input  logic        fetch_ready,
    input  logic [31:0] inst,
    input  logic [31:0] inst_addr,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc,
    output logic        dec_pred_taken,
    output logic [31:0] dec_pred_pc
);
    localparam int DEPTH = 1 << QUEUE_ADDR_W;
    localparam logic [QUEUE_ADDR_W:0] DEPTH_CNT = (QUEUE_ADDR_W + 1)'(DEPTH);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                  state_reg;
    logic [31:0]             fetch_pc_reg;
    logic [QUEUE_ADDR_W-1:0] head_reg;
    logic [QUEUE_ADDR_W-1:0] tail_reg;
    logic [QUEUE_ADDR_W:0]   count_reg;

    logic [31:0] inst_mem    [DEPTH];
    logic [31:0] pc_mem      [DEPTH];
    logic [31:0] pred_pc_mem [DEPTH];
    logic        taken_mem   [DEPTH];

    logic                  push;
    logic                  pop;
    logic [QUEUE_ADDR_W:0] count_next;
    logic [31:0]           next_pc;
    logic                  pred_taken;

    // Only a word whose address matches the outstanding request is accepted.
    assign push = (state_reg == WAIT) && fetch_ready && (inst_addr == fetch_pc_reg);
    assign pop  = (count_reg != '0) && dec_ready;
    assign count_next = count_reg + {{QUEUE_ADDR_W{1'b0}}, push} - {{QUEUE_ADDR_W{1'b0}}, pop};

`ifdef STATIC_BRANCH_PREDICT_EN
    logic [31:0] j_imm;
    logic [31:0] b_imm;

    assign j_imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    assign b_imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};

    // Backward conditional branches are assumed taken (loops); JAL is always taken.
    always_comb begin
        pred_taken = 1'b0;
        next_pc    = fetch_pc_reg + 32'd4;
        if (inst[6:0] == 7'b1101111) begin
            pred_taken = 1'b1;
            next_pc    = fetch_pc_reg + j_imm;
        end else if ((inst[6:0] == 7'b1100011) && inst[31]) begin
            pred_taken = 1'b1;
            next_pc    = fetch_pc_reg + b_imm;
        end
    end
`else
    assign pred_taken = 1'b0;
    assign next_pc    = fetch_pc_reg + 32'd4;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= RESET_PC;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
        end else if (rob_clear_up) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= rob_new_pc;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
        end else if (rdy_in) begin
            if (pop) begin
                head_reg <= head_reg + 1'b1;
            end
            if (push) begin
                tail_reg     <= tail_reg + 1'b1;
                fetch_pc_reg <= next_pc;
            end
            count_reg <= count_next;
            case (state_reg)
                IDLE: begin
                    if (count_reg < DEPTH_CNT) begin
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (push && (count_next >= DEPTH_CNT)) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Storage is never reset; validity is tracked entirely by count_reg.
    always_ff @(posedge clk_in) begin
        if (!rst_in && !rob_clear_up && rdy_in && push) begin
            inst_mem[tail_reg]    <= inst;
            pc_mem[tail_reg]      <= fetch_pc_reg;
            pred_pc_mem[tail_reg] <= next_pc;
            taken_mem[tail_reg]   <= pred_taken;
        end
    end

    assign start_fetch    = (state_reg == WAIT);
    assign pc             = fetch_pc_reg;
    assign dec_valid      = (count_reg != '0);
    assign dec_inst       = dec_valid ? inst_mem[head_reg]    : 32'h0;
    assign dec_pc         = dec_valid ? pc_mem[head_reg]      : 32'h0;
    assign dec_pred_pc    = dec_valid ? pred_pc_mem[head_reg] : 32'h0;
    assign dec_pred_taken = dec_valid ? taken_mem[head_reg]   : 1'b0;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized bench for inst_fetch_queue against a queue-based reference model of the fetch stage.
module tb_inst_fetch_queue;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        rob_clear_up;
    logic [31:0] rob_new_pc;
    logic        start_fetch;
    logic [31:0] pc;
    logic        fetch_ready;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic        dec_pred_taken;
    logic [31:0] dec_pred_pc;

    always #5 clk_in = ~clk_in;

    inst_fetch_queue dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .rob_clear_up   (rob_clear_up),
        .rob_new_pc     (rob_new_pc),
        .start_fetch    (start_fetch),
        .pc             (pc),
        .fetch_ready    (fetch_ready),
        .inst           (inst),
        .inst_addr      (inst_addr),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_inst       (dec_inst),
        .dec_pc         (dec_pc),
        .dec_pred_taken (dec_pred_taken),
        .dec_pred_pc    (dec_pred_pc)
    );

    typedef struct {
        logic [31:0] word;
        logic [31:0] addr;
        logic        taken;
        logic [31:0] target;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] m_pc;
    logic        m_wait;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h expected=%h", tag, got, exp);
    endtask

    function automatic void predict(input logic [31:0] w, input logic [31:0] p,
                                    output logic t, output logic [31:0] n);
        longint imm;
        t = 1'b0;
        n = p + 32'd4;
        imm = 0;
`ifdef STATIC_BRANCH_PREDICT_EN
        if (w[6:0] == 7'h6F) begin
            imm = (w[31] ? -(64'sd1 <<< 20) : 0) + longint'(w[19:12]) * 4096
                  + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
            t = 1'b1;
            n = p + 32'(imm);
        end else if (w[6:0] == 7'h63 && w[31]) begin
            imm = -(64'sd1 <<< 12) + longint'(w[7]) * 2048
                  + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
            t = 1'b1;
            n = p + 32'(imm);
        end
`endif
    endfunction

    // One clock edge of the fetch stage, as a queue plus an "outstanding request" flag.
    task automatic model_step();
        entry_t e;
        int     old_size;
        if (rst_in) begin
            m_pc = 32'h0; m_wait = 1'b0; mq.delete();
        end else if (rob_clear_up) begin
            m_pc = rob_new_pc; m_wait = 1'b0; mq.delete();
        end else if (rdy_in) begin
            old_size = mq.size();
            if (old_size > 0 && dec_ready) void'(mq.pop_front());
            if (m_wait && fetch_ready && inst_addr == m_pc) begin
                e.word = inst;
                e.addr = m_pc;
                predict(inst, m_pc, e.taken, e.target);
                mq.push_back(e);
                m_pc = e.target;
                m_wait = (mq.size() < 8);
            end else if (!m_wait) begin
                m_wait = (old_size < 8);
            end
        end
    endtask

    task automatic check_outputs(input int cyc);
        logic        v;
        entry_t      h;
        v = (mq.size() != 0);
        if (v) h = mq[0];
        else begin h.word = 0; h.addr = 0; h.taken = 0; h.target = 0; end
        check_val("start_fetch", {31'b0, start_fetch}, {31'b0, m_wait});
        check_val("pc", pc, m_pc);
        check_val("dec_valid", {31'b0, dec_valid}, {31'b0, v});
        check_val("dec_inst", dec_inst, h.word);
        check_val("dec_pc", dec_pc, h.addr);
        check_val("dec_pred_taken", {31'b0, dec_pred_taken}, {31'b0, h.taken});
        check_val("dec_pred_pc", dec_pred_pc, h.target);
        $display("cyc %0d rst=%0b clr=%0b rdy=%0b sf=%0b pc=%h fr=%0b dv=%0b dpc=%h depth=%0d",
                 cyc, rst_in, rob_clear_up, rdy_in, start_fetch, pc, fetch_ready,
                 dec_valid, dec_pc, mq.size());
    endtask

    function automatic logic [31:0] gen_word();
        int r;
        r = $urandom % 4;
        if (r == 0) return ($urandom & 32'hFFFF_FF80) | 32'h6F;
        if (r == 1) return ($urandom & 32'hFFFF_FF80) | 32'h63;
        return $urandom;
    endfunction

    initial begin
        m_pc = 0; m_wait = 0;
        rst_in = 1; rdy_in = 1; rob_clear_up = 0; rob_new_pc = 0;
        fetch_ready = 0; inst = 0; inst_addr = 0; dec_ready = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk_in);
            if (cyc > 0) check_outputs(cyc);
            rst_in       = (cyc < 3) || ($urandom % 600 == 0);
            rdy_in       = 1'b1;
            rob_clear_up = 1'b0;
            rob_new_pc   = $urandom & 32'hFFFF_FFFC;
            inst         = gen_word();
            if (m_wait) begin
                fetch_ready = ($urandom % 3 == 0);
                inst_addr   = ($urandom % 8 == 0) ? (m_pc ^ 32'h4) : m_pc;
            end else begin
                fetch_ready = ($urandom % 6 == 0);
                inst_addr   = $urandom;
            end
            if (cyc < 200) begin
                dec_ready = ($urandom % 2 == 0);
            end else if (cyc < 400) begin
                dec_ready = 1'b0;
            end else if (cyc < 405) begin
                rdy_in = 1'b0; dec_ready = 1'b1; fetch_ready = 1'b1; inst_addr = m_pc;
            end else begin
                dec_ready    = ((cyc / 50) % 3 == 0) ? ($urandom % 8 == 0) : ($urandom % 2 == 0);
                rdy_in       = ($urandom % 8 != 0);
                rob_clear_up = ($urandom % 40 == 0);
                if ($urandom % 4 == 0) rob_new_pc = 32'h100;
            end
            if (cyc == 420) begin
                inst = 32'h0080_006F;
            end
            @(posedge clk_in);
            model_step();
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
